// File: rtl/sumrest_sg_mag_serial_pkg.sv
// Shared types and defaults for the bit-serial sign-magnitude adder/subtractor.
// Holds the FSM state encoding, the add/subtract mode encoding and the default width.
package sumrest_sg_mag_serial_pkg;

  localparam int W_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SER  = 2'd1,
    FIX  = 2'd2
  } state_t;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } mode_t;

endpackage

// File: rtl/sumrest_sg_mag_serial_fa_sub_1b.sv
// One-bit combinational cell: a full adder when sub=0, a full subtractor when sub=1.
// When subtracting, cout is the borrow out of x - y - cin.
module fa_sub_1b (
  input  logic x,
  input  logic y,
  input  logic cin,
  input  logic sub,
  output logic s,
  output logic cout
);

  logic x_xor_y;

  assign x_xor_y = x ^ y;
  assign s       = x_xor_y ^ cin;
  // A borrow happens when y exceeds x, or when they match and a borrow is pending.
  assign cout    = sub ? ((~x & y) | (~x_xor_y & cin))
                       : ((x & y) | (x_xor_y & cin));

endmodule

// File: rtl/sumrest_sg_mag_serial.sv
// Bit-serial sign-magnitude adder/subtractor: one magnitude bit per clock, LSB first,
// followed by a fix-up cycle that settles the sign and the final magnitude.
module sumrest_sg_mag_serial
  import sumrest_sg_mag_serial_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] res,
  output logic         ovf,
  output logic         busy,
  output logic         done,
  output logic [1:0]   dbg_state
);

  localparam int M  = W - 1;
  localparam int CW = (M > 1) ? $clog2(M) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(M - 1);

  // Handshake: a request is taken on a rising edge where start=1 and busy=0;
  // op/a/b are sampled on that same edge. busy stays high until the fix-up edge,
  // after which done pulses for exactly one cycle and res/ovf are valid and held.

  state_t          state_q, state_d;
  mode_t           mode_q;
  logic [M-1:0]    a_sh, b_sh, r_sh;
  logic            carry_q;
  logic            sa_q, sb_eff_q;
  logic [CW-1:0]   cnt_q;
  logic            bit_s, bit_cout;
  logic            neg_diff;
  logic [M-1:0]    mag_fin;
  logic            sign_fin;

  fa_sub_1b u_cell (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .cin  (carry_q),
    .sub  (mode_q == SUB),
    .s    (bit_s),
    .cout (bit_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SER;
      SER:     if (cnt_q == CNT_LAST) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

  // A final borrow means B_mag > A_mag: the stored difference is the negated result.
  always_comb begin
    neg_diff = (mode_q == SUB) && carry_q;
    mag_fin  = neg_diff ? (~r_sh + {{(M-1){1'b0}}, 1'b1}) : r_sh;
    sign_fin = neg_diff ? sb_eff_q : sa_q;
    if (mag_fin == '0) sign_fin = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      r_sh     <= '0;
      carry_q  <= 1'b0;
      sa_q     <= 1'b0;
      sb_eff_q <= 1'b0;
      mode_q   <= ADD;
      cnt_q    <= '0;
      res      <= '0;
      ovf      <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh     <= a[M-1:0];
            b_sh     <= b[M-1:0];
            r_sh     <= '0;
            carry_q  <= 1'b0;
            sa_q     <= a[W-1];
            sb_eff_q <= b[W-1] ^ op;
            mode_q   <= (a[W-1] == (b[W-1] ^ op)) ? ADD : SUB;
            cnt_q    <= '0;
          end
        end
        SER: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          r_sh    <= (r_sh >> 1) | (M'(bit_s) << (M - 1));
          carry_q <= bit_cout;
          cnt_q   <= cnt_q + 1'b1;
        end
        FIX: begin
          res  <= {sign_fin, mag_fin};
          ovf  <= (mode_q == ADD) && carry_q;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sumrest_sg_mag_serial.sv
// Directed bench for the serial sign-magnitude adder/subtractor at W=4:
// vector table for the arithmetic plus hand-written control sequences.
module tb_sumrest_sg_mag_serial;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         op;
  logic [W-1:0] a, b;
  logic [W-1:0] res;
  logic         ovf, busy, done;
  logic [1:0]   dbg_state;

  int total = 0;
  int bad   = 0;

  sumrest_sg_mag_serial #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .res       (res),
    .ovf       (ovf),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_res;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called #1 after a posedge: drive a request and step past the accepting edge.
  task automatic issue(input logic o, input logic [W-1:0] aa, input logic [W-1:0] bb);
    start = 1'b1;
    op    = o;
    a     = aa;
    b     = bb;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Called #1 after the accepting edge; counts edges until done is seen.
  task automatic wait_done(output int lat, output int bcyc);
    lat  = 0;
    bcyc = busy ? 1 : 0;
    while (1) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) bcyc++;
      if (done || lat >= 20) break;
    end
    if (!done) chk("done_timeout", 32'(lat), 32'd4);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int lat, bcyc;
    issue(v.op, v.a, v.b);
    wait_done(lat, bcyc);
    chk({name, "_res"}, 32'(res), 32'(v.exp_res));
    chk({name, "_ovf"}, 32'(ovf), 32'(v.exp_ovf));
    chk({name, "_lat"}, 32'(lat), 32'd4);
    chk({name, "_busy_cycles"}, 32'(bcyc), 32'd4);
    @(posedge clk);
    #1;
    chk({name, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat, bcyc;

    vecs[0]  = '{1'b0, 4'b0011, 4'b0010, 4'b0101, 1'b0}; // 3+2
    vecs[1]  = '{1'b0, 4'b0101, 4'b0100, 4'b0001, 1'b1}; // 5+4 overflow
    vecs[2]  = '{1'b0, 4'b0100, 4'b0100, 4'b0000, 1'b1}; // 4+4 overflow, zero mag
    vecs[3]  = '{1'b1, 4'b0010, 4'b0101, 4'b1011, 1'b0}; // 2-5
    vecs[4]  = '{1'b1, 4'b1100, 4'b1110, 4'b0010, 1'b0}; // -4-(-6)
    vecs[5]  = '{1'b0, 4'b1011, 4'b0011, 4'b0000, 1'b0}; // -3+3
    vecs[6]  = '{1'b0, 4'b1000, 4'b0010, 4'b0010, 1'b0}; // -0+2
    vecs[7]  = '{1'b1, 4'b0111, 4'b1111, 4'b0110, 1'b1}; // 7-(-7)=14
    vecs[8]  = '{1'b0, 4'b1111, 4'b1001, 4'b0000, 1'b1}; // -7+-1=-8
    vecs[9]  = '{1'b1, 4'b1011, 4'b1010, 4'b1001, 1'b0}; // -3-(-2)
    vecs[10] = '{1'b0, 4'b0110, 4'b1011, 4'b0011, 1'b0}; // 6+-3
    vecs[11] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0}; // 0-0

    rst_n = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_res", 32'(res), 32'd0);
    chk("reset_ovf", 32'(ovf), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // start pulsed while busy must not disturb the in-flight operation
    issue(1'b0, 4'b0011, 4'b0010);
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = 1'b1;
    a     = 4'b0111;
    b     = 4'b0001;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("ignore_busy_res", 32'(res), 32'h5);
    chk("ignore_busy_ovf", 32'(ovf), 32'd0);
    @(posedge clk);
    #1;
    chk("ignore_busy_idle", 32'(busy), 32'd0);

    // reset at the second serial edge aborts with everything cleared
    issue(1'b1, 4'b0010, 4'b0101);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_res", 32'(res), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_vec("after_abort", vecs[3]);

    // start held high through done: the next request is taken right after done
    issue(1'b0, 4'b0101, 4'b0100);
    start = 1'b1;
    wait_done(lat, bcyc);
    chk("b2b_first_res", 32'(res), 32'h1);
    chk("b2b_first_ovf", 32'(ovf), 32'd1);
    chk("b2b_first_lat", 32'(lat), 32'd4);
    op = 1'b1;
    a  = 4'b1100;
    b  = 4'b1110;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_accept_busy", 32'(busy), 32'd1);
    chk("b2b_res_held", 32'(res), 32'h1);
    chk("b2b_ovf_held", 32'(ovf), 32'd1);
    wait_done(lat, bcyc);
    chk("b2b_second_res", 32'(res), 32'h2);
    chk("b2b_second_ovf", 32'(ovf), 32'd0);
    chk("b2b_second_lat", 32'(lat), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
